// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single 256-bit memory line port between the icache and the dcache.
// Latency: a request seen in IDLE drives the memory strobe next cycle; every response is followed by one IDLE bubble.
// Backpressure: the losing cache keeps its request asserted and is served after the owner's mem_resp.
module cache_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // icache side
  input  logic             i_pmem_read,
  input  logic [31:0]      i_pmem_address,
  output logic [255:0]     i_pmem_rdata,
  output logic             i_pmem_resp,
  // dcache side
  input  logic             d_pmem_read,
  input  logic             d_pmem_write,
  input  logic [31:0]      d_pmem_address,
  input  logic [255:0]     d_pmem_wdata,
  output logic [255:0]     d_pmem_rdata,
  output logic             d_pmem_resp,
  // memory adaptor side
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_resp,
  // performance counters
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // Everything the arbiter forwards to the adaptor for one transaction.
  typedef struct packed {
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [255:0] wdata;
  } mem_req_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             last_grant;   // 0 = icache served last, 1 = dcache served last
  logic [CNT_W-1:0] i_cnt;
  logic [CNT_W-1:0] d_cnt;
  logic [CNT_W-1:0] c_cnt;

  logic             ireq;
  logic             dreq;
  mem_req_t         req;

  assign ireq = i_pmem_read;
  // A write-back and a fill are both "dcache wants memory".
  assign dreq = d_pmem_read | d_pmem_write;

  // Counters stick at all-ones so long runs never wrap back to small values.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Grant FSM, round-robin tie history and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      i_cnt      <= '0;
      d_cnt      <= '0;
      c_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // mem_resp here belongs to no one and is deliberately ignored.
          if (ireq && dreq) begin
            c_cnt <= sat_inc(c_cnt);
            // Round-robin: the cache that was not served last wins the tie.
            state <= last_grant ? SERVE_I : SERVE_D;
          end else if (ireq) begin
            state <= SERVE_I;
          end else if (dreq) begin
            state <= SERVE_D;
          end
        end
        SERVE_I: begin
          // Ownership is held until the adaptor answers, even if the request drops.
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            i_cnt      <= sat_inc(i_cnt);
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            d_cnt      <= sat_inc(d_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owning cache's request to memory and the response back to it only.
  always_comb begin
    req         = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      SERVE_I: begin
        req.read    = i_pmem_read;
        req.address = i_pmem_address;
        i_pmem_resp = mem_resp;
      end
      SERVE_D: begin
        // Read and write together is illegal from the dcache; the write takes priority.
        req.read    = d_pmem_read & ~d_pmem_write;
        req.write   = d_pmem_write;
        req.address = d_pmem_address;
        req.wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
      end
      default: begin
        req = '0;
      end
    endcase
  end

  assign mem_read     = req.read;
  assign mem_write    = req.write;
  assign mem_address  = req.address;
  assign mem_wdata    = req.wdata;

  // Read data is broadcast; the resp pulse tells each cache whether it is meant for it.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  assign i_grant_cnt  = i_cnt;
  assign d_grant_cnt  = d_cnt;
  assign conflict_cnt = c_cnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed cycle table, reset/saturation sequences, randomized run against a reference model.
// Counters are instantiated narrow so saturation is reachable in a short run.
module tb_cache_arbiter;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_pmem_read;
  logic [31:0]    i_pmem_address;
  logic [255:0]   i_pmem_rdata;
  logic           i_pmem_resp;
  logic           d_pmem_read;
  logic           d_pmem_write;
  logic [31:0]    d_pmem_address;
  logic [255:0]   d_pmem_wdata;
  logic [255:0]   d_pmem_rdata;
  logic           d_pmem_resp;
  logic           mem_read;
  logic           mem_write;
  logic [31:0]    mem_address;
  logic [255:0]   mem_wdata;
  logic [255:0]   mem_rdata;
  logic           mem_resp;
  logic [CW-1:0]  i_grant_cnt;
  logic [CW-1:0]  d_grant_cnt;
  logic [CW-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One directed cycle: inputs applied, then outputs and counters expected in that same cycle.
  // ewd: 0 = mem_wdata must be 0, 1 = must equal d_pmem_wdata, 2 = not checked.
  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] da;
    logic        mr;
    logic        erd, ewr;
    logic [31:0] ea;
    logic        eir, edr;
    int          ewd;
    int          eic, edc, ecc;
  } vec_t;

  function automatic vec_t v(input logic ir, input logic dr, input logic dw, input logic [31:0] da,
                             input logic mr, input logic erd, input logic ewr, input logic [31:0] ea,
                             input logic eir, input logic edr, input int ewd,
                             input int eic, input int edc, input int ecc);
    vec_t r;
    r.ir = ir; r.dr = dr; r.dw = dw; r.da = da; r.mr = mr;
    r.erd = erd; r.ewr = ewr; r.ea = ea; r.eir = eir; r.edr = edr;
    r.ewd = ewd; r.eic = eic; r.edc = edc; r.ecc = ecc;
    return r;
  endfunction

  localparam logic [31:0] IA = 32'h0000_0040;
  localparam logic [31:0] DA = 32'h0000_1000;
  localparam logic [31:0] DB = 32'h0000_2000;

  vec_t tbl[$];

  // Reference model state (owner: 0 none, 1 icache, 2 dcache).
  int m_owner, m_last, m_ic, m_dc, m_cc;
  int n_owner, n_last, n_ic, n_dc, n_cc;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  initial begin
    logic [255:0] a5;
    logic [255:0] dead;
    logic         e_rd, e_wr, e_ir, e_dr;
    logic [31:0]  e_a;
    logic [255:0] e_wd;
    a5   = {32{8'hA5}};
    dead = {8{32'hDEAD_BEEF}};

    // Test plan 1: icache fill, resp 4 cycles after mem_read first seen.
    tbl.push_back(v(1,0,0,DA,0, 0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(v(1,0,0,DA,0, 1,0,IA, 0,0,2, 0,0,0));
    tbl.push_back(v(1,0,0,DA,0, 1,0,IA, 0,0,2, 0,0,0));
    tbl.push_back(v(1,0,0,DA,0, 1,0,IA, 0,0,2, 0,0,0));
    tbl.push_back(v(1,0,0,DA,0, 1,0,IA, 0,0,2, 0,0,0));
    tbl.push_back(v(1,0,0,DA,1, 1,0,IA, 1,0,2, 0,0,0));
    tbl.push_back(v(0,0,0,DA,0, 0,0,0,  0,0,0, 1,0,0));
    // Test plan 4: stray mem_resp in IDLE is ignored.
    tbl.push_back(v(0,0,0,DA,1, 0,0,0,  0,0,0, 1,0,0));
    tbl.push_back(v(0,0,0,DA,0, 0,0,0,  0,0,0, 1,0,0));
    // Test plan 2: tie -> dcache, bubble, tie -> icache, bubble, tie -> dcache.
    tbl.push_back(v(1,1,0,DA,0, 0,0,0,  0,0,0, 1,0,0));
    tbl.push_back(v(1,1,0,DA,0, 1,0,DA, 0,0,1, 1,0,1));
    tbl.push_back(v(1,1,0,DA,1, 1,0,DA, 0,1,1, 1,0,1));
    tbl.push_back(v(1,1,0,DA,0, 0,0,0,  0,0,0, 1,1,1));
    tbl.push_back(v(1,1,0,DA,1, 1,0,IA, 1,0,2, 1,1,2));
    tbl.push_back(v(1,1,0,DA,0, 0,0,0,  0,0,0, 2,1,2));
    // read+write together behaves as a write
    tbl.push_back(v(1,1,1,DA,0, 0,1,DA, 0,0,1, 2,1,3));
    // dcache drops its request while owning memory: strobes fall, ownership holds
    tbl.push_back(v(1,0,0,DA,0, 0,0,DA, 0,0,1, 2,1,3));
    tbl.push_back(v(1,0,0,DA,1, 0,0,DA, 0,1,1, 2,1,3));
    tbl.push_back(v(0,0,0,DA,0, 0,0,0,  0,0,0, 2,2,3));
    // Test plan 3: write-back to 0x1000 then fill from 0x2000.
    tbl.push_back(v(0,0,1,DA,0, 0,0,0,  0,0,0, 2,2,3));
    tbl.push_back(v(0,0,1,DA,0, 0,1,DA, 0,0,1, 2,2,3));
    tbl.push_back(v(0,0,1,DA,1, 0,1,DA, 0,1,1, 2,2,3));
    tbl.push_back(v(0,1,0,DB,0, 0,0,0,  0,0,0, 2,3,3));
    tbl.push_back(v(0,1,0,DB,0, 1,0,DB, 0,0,1, 2,3,3));
    tbl.push_back(v(0,1,0,DB,1, 1,0,DB, 0,1,1, 2,3,3));
    tbl.push_back(v(0,0,0,DB,0, 0,0,0,  0,0,0, 2,4,3));

    // Reset state
    rst_n = 1'b0; i_pmem_read = 0; i_pmem_address = IA;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = DA; d_pmem_wdata = dead;
    mem_rdata = a5; mem_resp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {mem_read, mem_write}, 2'b00);
    chk("reset_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("reset_addr", mem_address, 32'h0);
    chk("reset_cnts", {i_grant_cnt, d_grant_cnt, conflict_cnt}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      i_pmem_read = tbl[k].ir; d_pmem_read = tbl[k].dr; d_pmem_write = tbl[k].dw;
      d_pmem_address = tbl[k].da; mem_resp = tbl[k].mr;
      @(negedge clk);
      chk($sformatf("row%0d_strobes", k), {mem_read, mem_write}, {tbl[k].erd, tbl[k].ewr});
      chk($sformatf("row%0d_addr", k), mem_address, tbl[k].ea);
      chk($sformatf("row%0d_resp", k), {i_pmem_resp, d_pmem_resp}, {tbl[k].eir, tbl[k].edr});
      if (tbl[k].ewd != 2)
        chk($sformatf("row%0d_wdata", k), mem_wdata, (tbl[k].ewd == 1) ? dead : 256'h0);
      chk($sformatf("row%0d_irdata", k), i_pmem_rdata, a5);
      chk($sformatf("row%0d_drdata", k), d_pmem_rdata, a5);
      chk($sformatf("row%0d_icnt", k), i_grant_cnt, tbl[k].eic[CW-1:0]);
      chk($sformatf("row%0d_dcnt", k), d_grant_cnt, tbl[k].edc[CW-1:0]);
      chk($sformatf("row%0d_ccnt", k), conflict_cnt, tbl[k].ecc[CW-1:0]);
      @(posedge clk); #1;
    end

    // Test plan 5: reset while dcache owns memory, then first tie goes to dcache.
    i_pmem_read = 0; d_pmem_read = 1; d_pmem_write = 0; d_pmem_address = DA; mem_resp = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_served_read", mem_read, 1'b1);
    @(posedge clk); #1;
    rst_n = 0; i_pmem_read = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("t5_after_rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("t5_after_rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("t5_after_rst_cnts", {i_grant_cnt, d_grant_cnt, conflict_cnt}, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_tie_dcache_read", {mem_read, mem_write}, 2'b10);
    chk("t5_tie_dcache_addr", mem_address, DA);
    chk("t5_tie_ccnt", conflict_cnt, CW'(1));
    mem_resp = 1;
    @(posedge clk); #1;
    mem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;

    // Test plan 6: icache counter saturates at all-ones.
    for (int n = 0; n < CMAX + 3; n++) begin
      i_pmem_read = 1; mem_resp = 0;
      @(posedge clk); #1;
      mem_resp = 1;
      @(posedge clk); #1;
    end
    mem_resp = 0; i_pmem_read = 0;
    @(negedge clk);
    chk("t6_icnt_saturated", i_grant_cnt, {CW{1'b1}});
    chk("t6_dcnt_kept", d_grant_cnt, CW'(1));
    chk("t6_ccnt_kept", conflict_cnt, CW'(1));
    @(posedge clk); #1;

    // Randomized run against the reference model.
    rst_n = 0;
    @(posedge clk); #1;
    m_owner = 0; m_last = 0; m_ic = 0; m_dc = 0; m_cc = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      i_pmem_read    = ($urandom_range(0, 9) < 6);
      d_pmem_read    = ($urandom_range(0, 9) < 4);
      d_pmem_write   = ($urandom_range(0, 9) < 3);
      i_pmem_address = $urandom;
      d_pmem_address = $urandom;
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem_rdata      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem_resp       = ($urandom_range(0, 9) < 3);

      e_rd = 0; e_wr = 0; e_a = 0; e_wd = 0; e_ir = 0; e_dr = 0;
      if (m_owner == 1) begin
        e_rd = i_pmem_read; e_a = i_pmem_address; e_ir = mem_resp;
      end else if (m_owner == 2) begin
        e_wr = d_pmem_write; e_rd = d_pmem_read && !d_pmem_write;
        e_a = d_pmem_address; e_wd = d_pmem_wdata; e_dr = mem_resp;
      end

      @(negedge clk);
      chk("rnd_strobes", {mem_read, mem_write}, {e_rd, e_wr});
      chk("rnd_addr", mem_address, e_a);
      if (m_owner != 1) chk("rnd_wdata", mem_wdata, e_wd);
      chk("rnd_resp", {i_pmem_resp, d_pmem_resp}, {e_ir, e_dr});
      chk("rnd_rdata", {i_pmem_rdata == mem_rdata, d_pmem_rdata == mem_rdata}, 2'b11);
      chk("rnd_icnt", i_grant_cnt, m_ic[CW-1:0]);
      chk("rnd_dcnt", d_grant_cnt, m_dc[CW-1:0]);
      chk("rnd_ccnt", conflict_cnt, m_cc[CW-1:0]);

      n_owner = m_owner; n_last = m_last; n_ic = m_ic; n_dc = m_dc; n_cc = m_cc;
      if (!rst_n) begin
        n_owner = 0; n_last = 0; n_ic = 0; n_dc = 0; n_cc = 0;
      end else if (m_owner == 0) begin
        if (i_pmem_read && (d_pmem_read || d_pmem_write)) begin
          n_cc = sat(m_cc + 1);
          n_owner = (m_last == 1) ? 1 : 2;
        end else if (i_pmem_read) n_owner = 1;
        else if (d_pmem_read || d_pmem_write) n_owner = 2;
      end else if (mem_resp) begin
        if (m_owner == 1) begin n_last = 0; n_ic = sat(m_ic + 1); end
        else begin n_last = 1; n_dc = sat(m_dc + 1); end
        n_owner = 0;
      end

      @(posedge clk); #1;
      m_owner = n_owner; m_last = n_last; m_ic = n_ic; m_dc = n_dc; m_cc = n_cc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
